chaos_subst_ctrl: RTL and testbench

- Sequencer for the chaos-cipher pixel substitution stage.
- Walks an image in raster order from a synchronous-read pixel memory and keeps the previous row in an internal line buffer.
- Computes the neighbourhood-sum-mod-F substitution one pixel at a time and writes each result through a valid/ready write port.
- Sits between the image frame store and the permutation/diffusion stages; started by the top-level cipher controller.

---
 rtl/chaos_subst_pkg.sv | 25 ++
 rtl/subst_mod_reduce.sv | 39 +++
 rtl/chaos_subst_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_chaos_subst_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/chaos_subst_pkg.sv
// ----------------------------------------------------------------------------
// chaos_subst_pkg
// Shared types and constants for the chaos-cipher pixel substitution stage.
//   subst_state_e : sequencer states (IDLE, RD, WAIT, CALC, WR, FIN)
//   PIX_W_DEF     : default pixel/key width
//   SUM_W         : width of the neighbourhood sum (four pixels -> +2 bits)
//   pix_t         : pixel word at the default width
// ----------------------------------------------------------------------------
package chaos_subst_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int SUM_W     = PIX_W_DEF + 2;

  typedef logic [PIX_W_DEF-1:0] pix_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    CALC = 3'd3,
    WR   = 3'd4,
    FIN  = 3'd5
  } subst_state_e;

endpackage

// File: rtl/subst_mod_reduce.sv
// ----------------------------------------------------------------------------
// subst_mod_reduce
// Combinational reduction of a SUM_W-bit sum modulo an PIX_W-bit modulus by
// restoring conditional subtraction of f<<k, from the largest shift down to 0.
//   sum : unsigned neighbourhood sum
//   f   : modulus (must be non-zero for a meaningful result)
//   rem : sum mod f, always < f when f != 0
// ----------------------------------------------------------------------------
module subst_mod_reduce
  import chaos_subst_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int SUM_W = chaos_subst_pkg::SUM_W
) (
  input  logic [SUM_W-1:0] sum,
  input  logic [PIX_W-1:0] f,
  output logic [PIX_W-1:0] rem
);

  // Wide enough to hold f shifted by SUM_W-1 without losing bits.
  localparam int RW = SUM_W + PIX_W;

  logic [RW-1:0] r;
  logic [RW-1:0] d;

  // Shifts start at SUM_W-1 rather than SUM_W-PIX_W: a small modulus (e.g.
  // f=16 against a sum of 800) needs more than three subtraction steps to
  // bring the remainder below f.
  always_comb begin
    r = RW'(sum);
    d = '0;
    for (int k = SUM_W - 1; k >= 0; k--) begin
      d = RW'(f) << k;
      if (r >= d) r = r - d;
    end
    rem = r[PIX_W-1:0];
  end

endmodule

// File: rtl/chaos_subst_ctrl.sv
// ----------------------------------------------------------------------------
// chaos_subst_ctrl
// Raster-order sequencer for the chaos-cipher pixel substitution stage. Each
// pixel is read from a synchronous-read frame store, combined with its
// original left, up and up-left neighbours (previous row kept in a line
// buffer) and reduced modulo F, then written out through a valid/ready port.
// Four cycles per pixel (RD, WAIT, CALC, WR) with the sink always ready.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, key_m/n/f        one-cycle start; keys sampled with it
//   busy, done, err         status; err flags a start with F==0
//   rd_en, rd_addr, rd_data frame-store read port (data 1 cycle after rd_en)
//   wr_valid/ready/addr/data result write port
//   stall_cnt               cycles with wr_valid high and wr_ready low
//
// Build option: define SUBST_STALL_CNT_EN to include the saturating stall
// counter; otherwise stall_cnt is tied to zero.
// ----------------------------------------------------------------------------
module chaos_subst_ctrl
  import chaos_subst_pkg::*;
#(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PIX_W-1:0]  key_m,
  input  logic [PIX_W-1:0]  key_n,
  input  logic [PIX_W-1:0]  key_f,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic [31:0]       stall_cnt
);

  localparam int SW = PIX_W + 2;
  localparam int JW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W*IMG_H - 1);

  subst_state_e      state_q;
  logic [JW-1:0]     j_q;
  logic              row_q;      // high once i > 0
  logic [ADDR_W-1:0] addr_q;     // i*IMG_W + j of the current pixel

  logic [PIX_W-1:0]  m_q, n_q, f_q;
  logic [PIX_W-1:0]  pix_p0;     // pixel captured at the end of WAIT
  logic [PIX_W-1:0]  left_q;
  logic [PIX_W-1:0]  upleft_q;
  logic [PIX_W-1:0]  lbuf [IMG_W];

  logic [SW-1:0]     sum;
  logic [PIX_W-1:0]  res;

  always_comb begin
    sum = SW'(pix_p0);
    if (!row_q && j_q == '0)
      sum = SW'(pix_p0) + SW'(n_q);
    else if (!row_q)
      sum = SW'(pix_p0) + SW'(m_q);
    else if (j_q == '0)
      sum = SW'(pix_p0) + SW'(lbuf[0]);
    else
      sum = SW'(pix_p0) + SW'(left_q) + SW'(lbuf[j_q]) + SW'(upleft_q);
  end

  subst_mod_reduce #(
    .PIX_W (PIX_W),
    .SUM_W (SW)
  ) u_reduce (
    .sum (sum),
    .f   (f_q),
    .rem (res)
  );

  // Sequencer: all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      j_q      <= '0;
      row_q    <= 1'b0;
      addr_q   <= '0;
    end else begin
      done  <= 1'b0;
      rd_en <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy   <= 1'b1;
            err    <= (key_f == '0);
            j_q    <= '0;
            row_q  <= 1'b0;
            addr_q <= '0;
            if (key_f == '0) begin
              state_q <= FIN;
              done    <= 1'b1;
            end else begin
              state_q <= RD;
              rd_en   <= 1'b1;
              rd_addr <= '0;
            end
          end
        end
        RD:   state_q <= WAIT;
        WAIT: state_q <= CALC;
        CALC: begin
          state_q  <= WR;
          wr_valid <= 1'b1;
          wr_addr  <= addr_q;
          wr_data  <= res;
        end
        WR: begin
          if (wr_ready) begin
            wr_valid <= 1'b0;
            if (addr_q == LAST_ADDR) begin
              state_q <= FIN;
              done    <= 1'b1;
            end else begin
              state_q <= RD;
              rd_en   <= 1'b1;
              rd_addr <= addr_q + 1'b1;
              addr_q  <= addr_q + 1'b1;
              if (j_q == JW'(IMG_W - 1)) begin
                j_q   <= '0;
                row_q <= 1'b1;
              end else begin
                j_q <= j_q + 1'b1;
              end
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Datapath registers and line buffer carry no reset.
  // upleft takes lbuf[j] before it is overwritten, so at column j+1 it holds
  // the row-above pixel at column j.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      m_q <= key_m;
      n_q <= key_n;
      f_q <= key_f;
    end
    if (state_q == WAIT)
      pix_p0 <= rd_data;
    if (state_q == CALC) begin
      upleft_q   <= lbuf[j_q];
      lbuf[j_q]  <= pix_p0;
      left_q     <= pix_p0;
    end
  end

`ifdef SUBST_STALL_CNT_EN
  logic [31:0] stall_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= '0;
    else if (state_q == IDLE && start)
      stall_q <= '0;
    else if (wr_valid && !wr_ready)
      stall_q <= sat_inc(stall_q);
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_chaos_subst_ctrl.sv
module tb_chaos_subst_ctrl;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 3;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int ADDR_W = $clog2(NPIX);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        key_m = '0, key_n = '0, key_f = '0;
  logic              busy, done, err, rd_en, wr_valid;
  logic              wr_ready = 1'b1;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [7:0]        rd_data = '0;
  logic [7:0]        wr_data;
  logic [31:0]       stall_cnt;

  logic [7:0]        mem [1<<ADDR_W];
  logic [ADDR_W+7:0] q [$];

  int total = 0;
  int bad   = 0;

  chaos_subst_ctrl #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .PIX_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_m     (key_m),
    .key_n     (key_n),
    .key_f     (key_f),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous-read frame store: data valid the cycle after rd_en.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int px(input int i, input int j);
    return int'(mem[ADDR_W'(i*IMG_W + j)]);
  endfunction

  // Reference substitution from the original image.
  function automatic logic [7:0] model(input int i, input int j,
                                       input logic [7:0] m, n, f);
    int s;
    if (i == 0 && j == 0) s = px(0, 0) + int'(n);
    else if (i == 0)      s = px(0, j) + int'(m);
    else if (j == 0)      s = px(i, 0) + px(i-1, 0);
    else                  s = px(i, j) + px(i, j-1) + px(i-1, j) + px(i-1, j-1);
    return 8'(s % int'(f));
  endfunction

  task automatic fill(input int mode, input logic [7:0] v);
    for (int k = 0; k < NPIX; k++)
      mem[ADDR_W'(k)] = (mode == 0) ? v : 8'($urandom_range(0, 255));
  endtask

  task automatic run_frame(input logic [7:0] m, n, f,
                           input int stall_pix, input int stall_len,
                           input int abort_pix, input bit restart);
    int cyc, popped, rdc, stalled, exp_done;
    logic [ADDR_W-1:0] exp_a;
    logic [7:0]        exp_d;
    q.delete();
    if (f != 0)
      for (int k = 0; k < NPIX; k++)
        q.push_back({ADDR_W'(k), model(k / IMG_W, k % IMG_W, m, n, f)});
    exp_done = (f == 0) ? 1 : 4*NPIX + 1 + stall_len;
    key_m = m; key_n = n; key_f = f; start = 1'b1;
    @(negedge clk);
    start = 1'b0; key_m = ~m; key_n = ~n; key_f = ~f;
    cyc = 1; popped = 0; rdc = 0; stalled = 0;
    forever begin
      if (cyc > 400) begin
        chk("timeout", 32'(cyc), 32'(exp_done));
        break;
      end
      if (cyc == 1) chk("rd_first", 32'(rd_en), 32'(f != 0));
      if (cyc == 20 && f != 0) chk("busy_mid", 32'(busy), 32'd1);
      if (rd_en) begin
        chk("rd_addr", 32'(rd_addr), 32'(rdc));
        rdc++;
      end
      if (restart && cyc == 10) begin
        start = 1'b1; key_m = m + 8'd3; key_n = n + 8'd3; key_f = f + 8'd1;
      end else begin
        start = 1'b0;
      end
      wr_ready = 1'b1;
      if (wr_valid) begin
        if (abort_pix == popped) begin
          rst_n = 1'b0;
          #1;
          chk("abort_valid", 32'(wr_valid), 32'd0);
          chk("abort_busy", 32'(busy), 32'd0);
          chk("abort_err", 32'(err), 32'd0);
          chk("abort_rd", 32'(rd_en), 32'd0);
          chk("abort_done", 32'(done), 32'd0);
          chk("abort_wdata", 32'(wr_data), 32'd0);
          chk("abort_waddr", 32'(wr_addr), 32'd0);
          @(negedge clk);
          rst_n = 1'b1;
          break;
        end
        if (q.size() == 0) begin
          chk("extra_wr", 32'd1, 32'd0);
        end else begin
          if (popped == stall_pix && stalled < stall_len) begin
            wr_ready = 1'b0;
            stalled++;
          end
          {exp_a, exp_d} = q[0];
          chk("wr_addr", 32'(wr_addr), 32'(exp_a));
          chk("wr_data", 32'(wr_data), 32'(exp_d));
          chk("wr_lt_f", 32'(wr_data < f), 32'd1);
          if (wr_ready) begin
            void'(q.pop_front());
            popped++;
          end
        end
      end
      if (done) begin
        chk("done_cyc", 32'(cyc), 32'(exp_done));
        chk("err", 32'(err), 32'(f == 0));
        chk("q_left", 32'(q.size()), 32'd0);
        chk("rd_total", 32'(rdc), (f == 0) ? 32'd0 : 32'(NPIX));
`ifdef SUBST_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, 32'(stall_len));
`else
        chk("stall_cnt", stall_cnt, 32'd0);
`endif
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("busy_end", 32'(busy), 32'd0);
        break;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    wr_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Flat image, wide modulus: 15 / 17 / 20 / 40.
    fill(0, 8'd10);
    run_frame(8'd7, 8'd5, 8'd251, -1, 0, -1, 1'b0);

    // Flat bright image, small modulus: 13 / 15 / 0 / 0.
    fill(0, 8'd200);
    run_frame(8'd7, 8'd5, 8'd16, -1, 0, -1, 1'b0);

    // Zero modulus: no reads, err set, done next cycle.
    run_frame(8'd7, 8'd5, 8'd0, -1, 0, -1, 1'b0);

    // Random image with 3-cycle write stall on pixel 5 (also clears err).
    fill(1, 8'd0);
    run_frame(8'h3c, 8'ha5, 8'd97, 5, 3, -1, 1'b0);

    // Start while busy is ignored.
    run_frame(8'h3c, 8'ha5, 8'd97, -1, 0, -1, 1'b1);

    // Modulus 1 forces every result to zero.
    run_frame(8'h11, 8'h22, 8'd1, -1, 0, -1, 1'b0);

    // Abort at pixel 6, then a clean full frame.
    run_frame(8'h3c, 8'ha5, 8'd97, -1, 0, 6, 1'b0);
    run_frame(8'h5a, 8'h0f, 8'd255, -1, 0, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
